// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kgp_risc_pkg
// Description : Shared KGP-RISC definitions. Holds the fetch-unit state
//               encoding and the instruction field layout, which the
//               control unit also uses.
// Revision    : 1.0 - initial release
// ============================================================================
package kgp_risc_pkg;

    // Fetch/issue sequencer states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } ifu_state_t;

    // Instruction word layout: opcode | func | rs | rt | imm
    localparam int c_INSTR_W    = 32;
    localparam int c_OPCODE_W   = 2;
    localparam int c_FUNC_W     = 4;
    localparam int c_REG_W      = 5;
    localparam int c_IMM_W      = 16;

    localparam int c_OPCODE_LSB = 30;
    localparam int c_FUNC_LSB   = 26;
    localparam int c_RS_LSB     = 21;
    localparam int c_RT_LSB     = 16;
    localparam int c_IMM_LSB    = 0;

endpackage : kgp_risc_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundles the instruction-memory request/ack bus, the decode
//               valid/ready issue channel and the execute redirect into one
//               interface. The master modport is the fetch unit; the slave
//               modport is its environment (memory, decode, execute).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    import kgp_risc_pkg::*;

    // Instruction memory
    logic                  imem_req;
    logic [ADDR_W-1:0]     imem_addr;
    logic                  imem_ack;
    logic [c_INSTR_W-1:0]  imem_rdata;

    // Issue channel toward decode/control
    logic                  id_valid;
    logic                  id_ready;
    logic [c_OPCODE_W-1:0] id_opcode;
    logic [c_FUNC_W-1:0]   id_func;
    logic [c_REG_W-1:0]    id_rs;
    logic [c_REG_W-1:0]    id_rt;
    logic [c_IMM_W-1:0]    id_imm;
    logic [ADDR_W-1:0]     id_pc;

    // Redirect from execute
    logic                  redirect_valid;
    logic [ADDR_W-1:0]     redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output id_valid, id_opcode, id_func, id_rs, id_rt, id_imm, id_pc,
        input  id_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  id_valid, id_opcode, id_func, id_rs, id_rt, id_imm, id_pc,
        output id_ready,
        output redirect_valid, redirect_pc
    );

endinterface : instr_fetch_unit_if
`default_nettype wire

// File: rtl/instr_fetch_unit_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : ifu_perf_counters
// Description : Free-running 32-bit issue and stall event counters for the
//               fetch unit. Both wrap at 2^32 and clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_perf_counters (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_issue,
    input  wire logic        i_stall,
    output logic [31:0]      o_issued,
    output logic [31:0]      o_stall
);

    logic [31:0] r_issued;
    logic [31:0] r_stall;

    // Count accepted handshakes and stall cycles; natural 32-bit wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued <= '0;
            r_stall  <= '0;
        end else begin
            if (i_issue) r_issued <= r_issued + 32'd1;
            if (i_stall) r_stall  <= r_stall + 32'd1;
        end
    end

    assign o_issued = r_issued;
    assign o_stall  = r_stall;

endmodule : ifu_perf_counters
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : KGP-RISC instruction fetch and issue sequencer. Holds the PC,
//               fetches words over a req/ack bus, splits them into decode
//               fields and issues them over valid/ready. Execute redirects
//               reload the PC and flush in-flight work (DRAIN absorbs an
//               outstanding memory response).
//               Optional macro IFU_PERF_CNT_EN adds perf_issued/perf_stall.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    instr_fetch_unit_if.master   ifu
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    // Clears the two low address bits of a redirect target
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    ifu_state_t           r_state;
    ifu_state_t           w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [ADDR_W-1:0]    w_redir_pc;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic [c_INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]    r_id_pc;
    logic                 w_capture;
    logic                 w_fetch_act;

    assign w_redir_pc  = ifu.redirect_pc & c_ALIGN_MASK;
    assign w_pc_inc    = r_pc + ADDR_W'(4);
    // The request is held low while reset is asserted so it only rises after release
    assign w_fetch_act = (r_state == ST_FETCH) && !rst;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_state_nxt;
    end

    // Next-state, PC update and capture decisions; redirect has priority
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (ifu.redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    // An ack in the same cycle is simply dropped; otherwise
                    // the response is still owed and must be absorbed.
                    w_state_nxt = ifu.imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (ifu.imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ifu.redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = ST_FETCH;
                end else if (ifu.id_ready) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (ifu.redirect_valid) w_pc_nxt = w_redir_pc;
                if (ifu.imem_ack)       w_state_nxt = ST_FETCH;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Program counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_nxt;
    end

    // Issue register: instruction word and its PC, held stable through ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= '0;
            r_id_pc <= '0;
        end else if (w_capture) begin
            r_instr <= ifu.imem_rdata;
            r_id_pc <= r_pc;
        end
    end

    assign ifu.imem_req  = w_fetch_act;
    assign ifu.imem_addr = r_pc;
    assign ifu.id_valid  = (r_state == ST_ISSUE);
    assign ifu.id_opcode = r_instr[c_OPCODE_LSB +: c_OPCODE_W];
    assign ifu.id_func   = r_instr[c_FUNC_LSB   +: c_FUNC_W];
    assign ifu.id_rs     = r_instr[c_RS_LSB     +: c_REG_W];
    assign ifu.id_rt     = r_instr[c_RT_LSB     +: c_REG_W];
    assign ifu.id_imm    = r_instr[c_IMM_LSB    +: c_IMM_W];
    assign ifu.id_pc     = r_id_pc;

`ifdef IFU_PERF_CNT_EN
    logic w_issue_evt;
    logic w_stall_evt;

    // A handshake coinciding with a redirect still counts as an issue
    assign w_issue_evt = (r_state == ST_ISSUE) && ifu.id_ready;
    assign w_stall_evt = (w_fetch_act && !ifu.imem_ack) || (r_state == ST_DRAIN);

    ifu_perf_counters u_perf (
        .clk      (clk),
        .rst      (rst),
        .i_issue  (w_issue_evt),
        .i_stall  (w_stall_evt),
        .o_issued (perf_issued),
        .o_stall  (perf_stall)
    );
`endif

endmodule : instr_fetch_unit
`default_nettype wire
